// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode byte type and opcode constants shared by the CPU core
package cpu_pkg;

  typedef logic [7:0] opcode_t;

  // Register math
  localparam opcode_t ADD    = 8'h10;
  localparam opcode_t SUB    = 8'h12;
  localparam opcode_t MULTL  = 8'h14;
  localparam opcode_t MULTH  = 8'h16;
  localparam opcode_t LS     = 8'h20;
  localparam opcode_t RS     = 8'h22;
  localparam opcode_t ROR    = 8'h24;

  // Immediate math
  localparam opcode_t ADDI   = 8'h11;
  localparam opcode_t SUBI   = 8'h13;
  localparam opcode_t MULTLI = 8'h15;
  localparam opcode_t MULTHI = 8'h17;
  localparam opcode_t LSI    = 8'h21;
  localparam opcode_t RSI    = 8'h23;
  localparam opcode_t RORI   = 8'h25;

  // Memory
  localparam opcode_t LDI    = 8'h81;
  localparam opcode_t LDB    = 8'h85;
  localparam opcode_t STI    = 8'h83;
  localparam opcode_t STB    = 8'h87;

  // Control transfer
  localparam opcode_t BNEQ   = 8'h33;
  localparam opcode_t BLTZ   = 8'h35;
  localparam opcode_t BGTZ   = 8'h37;
  localparam opcode_t BLEZ   = 8'h39;
  localparam opcode_t BGEZ   = 8'h3B;
  localparam opcode_t JMP    = 8'h3D;
  localparam opcode_t JMPI   = 8'h3F;

  localparam opcode_t NOP    = 8'h00;

endpackage

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - combinational instruction decoder with optional sticky illegal-opcode flag
// Optional feature macro: CPU_CONTROL_STICKY_ERR_EN (implements the err_sticky flop).
module cpu_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic [7:0]  alu_op,
  output logic        alu_imm_src,
  output logic        rf_write_en,
  output logic        datamem_write_en,
  output logic        datamem_read_en,
  output logic        rf_write_mem_src,
  output logic        pc_src,
  output logic        pc_jmp_src,
  output logic        err,
  output logic        err_sticky
);

  opcode_t opcode;
  assign opcode = instr[31:24];

  always_comb begin
    alu_op           = 8'h00;
    alu_imm_src      = 1'b0;
    rf_write_en      = 1'b0;
    datamem_write_en = 1'b0;
    datamem_read_en  = 1'b0;
    rf_write_mem_src = 1'b0;
    pc_src           = 1'b0;
    pc_jmp_src       = 1'b0;
    err              = 1'b0;
    case (opcode)
      ADD, SUB, MULTL, MULTH, LS, RS, ROR: begin
        alu_op      = opcode;
        rf_write_en = 1'b1;
      end
      ADDI, SUBI, MULTLI, MULTHI, LSI, RSI, RORI: begin
        alu_op      = opcode;
        alu_imm_src = 1'b1;
        rf_write_en = 1'b1;
      end
      LDI, LDB: begin
        alu_op           = opcode;
        alu_imm_src      = 1'b1;
        rf_write_en      = 1'b1;
        datamem_read_en  = 1'b1;
        rf_write_mem_src = 1'b1;
      end
      STI, STB: begin
        alu_op           = opcode;
        alu_imm_src      = 1'b1;
        datamem_write_en = 1'b1;
      end
      // Branch condition is resolved downstream from ALU flags.
      BNEQ, BLTZ, BGTZ, BLEZ, BGEZ, JMP: begin
        alu_op = opcode;
        pc_src = 1'b1;
      end
      JMPI: begin
        alu_op     = opcode;
        pc_src     = 1'b1;
        pc_jmp_src = 1'b1;
      end
      NOP: begin
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

`ifdef CPU_CONTROL_STICKY_ERR_EN
  logic err_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_q | err;
    end
  end

  assign err_sticky = err_sticky_q;

  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[23:0]};
`else
  assign err_sticky = 1'b0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst_n, instr[23:0]};
`endif

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - directed self-checking bench for cpu_control
module tb_cpu_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [7:0]  alu_op;
  logic        alu_imm_src;
  logic        rf_write_en;
  logic        datamem_write_en;
  logic        datamem_read_en;
  logic        rf_write_mem_src;
  logic        pc_src;
  logic        pc_jmp_src;
  logic        err;
  logic        err_sticky;

  int checks;
  int failures;

  cpu_control dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr            (instr),
    .alu_op           (alu_op),
    .alu_imm_src      (alu_imm_src),
    .rf_write_en      (rf_write_en),
    .datamem_write_en (datamem_write_en),
    .datamem_read_en  (datamem_read_en),
    .rf_write_mem_src (rf_write_mem_src),
    .pc_src           (pc_src),
    .pc_jmp_src       (pc_jmp_src),
    .err              (err),
    .err_sticky       (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {alu_op, imm_src, rf_we, dm_we, dm_re, mem_src, pc_src, jmp_src, err}
  logic [15:0] dec_vec;
  assign dec_vec = {alu_op, alu_imm_src, rf_write_en, datamem_write_en, datamem_read_en,
                    rf_write_mem_src, pc_src, pc_jmp_src, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  localparam int NVEC = 22;
  logic [7:0]  vec_op  [NVEC] = '{8'h11, 8'h10, 8'h14, 8'h17, 8'h24, 8'h23,
                                  8'h85, 8'h81, 8'h83, 8'h87,
                                  8'h33, 8'h3B, 8'h3D, 8'h35, 8'h3F,
                                  8'hFF, 8'h00, 8'h18, 8'h3E, 8'h40, 8'h12, 8'h25};
  logic [15:0] vec_exp [NVEC] = '{16'h11C0, 16'h1040, 16'h1440, 16'h17C0, 16'h2440, 16'h23C0,
                                  16'h85D8, 16'h81D8, 16'h83A0, 16'h87A0,
                                  16'h3304, 16'h3B04, 16'h3D04, 16'h3504, 16'h3F06,
                                  16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0001,
                                  16'h1240, 16'h25C0};

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    instr    = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sticky", {31'd0, err_sticky}, 32'd0);
    check("reset_nop_decode", {16'd0, dec_vec}, 32'h0000_0000);

    // Decode is independent of reset.
    instr = 32'hFF12_3456;
    #1;
    check("decode_in_reset", {16'd0, dec_vec}, 32'h0000_0001);
    instr = 32'h0000_0000;

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      instr = {vec_op[i], 24'($urandom)};
      #1;
      check($sformatf("decode_%02h", vec_op[i]), {16'd0, dec_vec}, {16'd0, vec_exp[i]});
    end

`ifdef CPU_CONTROL_STICKY_ERR_EN
    // Fresh reset, then one illegal cycle followed by ADD.
    @(negedge clk);
    rst_n = 1'b0;
    instr = 32'h1000_0000;
    #1;
    check("sticky_cleared", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("sticky_legal_stays0", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    instr = 32'hFF00_0000;
    #1;
    check("sticky_before_edge", {31'd0, err_sticky}, 32'd0);
    @(posedge clk); #1;
    check("sticky_set", {31'd0, err_sticky}, 32'd1);
    @(negedge clk);
    instr = 32'h1000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("sticky_holds", {31'd0, err_sticky}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("sticky_async_clear", {31'd0, err_sticky}, 32'd0);

    // Release reset while err is already high.
    instr = 32'hFF00_0000;
    @(posedge clk); #1;
    check("sticky_held_in_reset", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sticky_after_release", {31'd0, err_sticky}, 32'd0);
    @(posedge clk); #1;
    check("sticky_first_edge", {31'd1 - 31'd1, err_sticky}, 32'd1);
`else
    @(negedge clk);
    instr = 32'hFF00_0000;
    repeat (3) @(posedge clk);
    #1;
    check("sticky_disabled", {31'd0, err_sticky}, 32'd0);
    check("err_unaffected", {31'd0, err}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
